// File: rtl/puf_key_accumulator_if.sv
// rtl/puf_key_accumulator_if.sv - key request/response and PUF drive signals; PUF_UNSTABLE_FLAG_EN adds stability flags
interface puf_key_accumulator_if;
    logic         start;
    logic [0:15]  seed;
    logic [0:15]  puf_resp;
    logic [0:15]  puf_challenge;
    logic         puf_rst;
    logic         busy;
    logic         key_valid;
    logic [0:127] key;
`ifdef PUF_UNSTABLE_FLAG_EN
    logic [0:127] unstable_mask;
    logic [7:0]   unstable_cnt;
`endif

    modport slave (
        input  start, seed, puf_resp,
        output puf_challenge, puf_rst, busy, key_valid, key
`ifdef PUF_UNSTABLE_FLAG_EN
        , output unstable_mask, unstable_cnt
`endif
    );

    modport master (
        output start, seed, puf_resp,
        input  puf_challenge, puf_rst, busy, key_valid, key
`ifdef PUF_UNSTABLE_FLAG_EN
        , input unstable_mask, unstable_cnt
`endif
    );
endinterface

// File: rtl/puf_key_accumulator.sv
// rtl/puf_key_accumulator.sv - PUF challenge sequencer with per-bit majority vote building a 128-bit key
// Optional PUF_UNSTABLE_FLAG_EN reports bits whose votes were not unanimous.
module puf_key_accumulator #(
    parameter int SETTLE_CYCLES = 64,
    parameter int NUM_SAMPLES   = 5
) (
    input logic                  clk,
    input logic                  Reset,
    puf_key_accumulator_if.slave bus
);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [3:0]    SAMPLE_LAST = 4'(NUM_SAMPLES - 1);
    localparam logic [3:0]    HALF        = 4'(NUM_SAMPLES / 2);

    typedef enum logic [2:0] {IDLE, PRST, SETTLE, CAP, VOTE} state_t;

    state_t        state, state_next;
    logic [SW-1:0] settle_cnt;
    logic [3:0]    sample_cnt;
    logic [2:0]    word_idx;
    logic [2:0]    word_next;
    logic [0:15]   seed_q;
    logic [0:15]   challenge_next;
    logic [0:15]   word_bits;
    logic [3:0]    votes [16];

`ifdef PUF_UNSTABLE_FLAG_EN
    localparam logic [3:0] ALL = 4'(NUM_SAMPLES);
    logic [0:15] flaky;
    logic [4:0]  flaky_cnt;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = PRST;
            PRST:    state_next = SETTLE;
            SETTLE:  if (settle_cnt == SETTLE_LAST) state_next = CAP;
            CAP:     state_next = (sample_cnt == SAMPLE_LAST) ? VOTE : PRST;
            VOTE:    state_next = (word_idx == 3'd7) ? IDLE : PRST;
            default: state_next = IDLE;
        endcase

        // The challenge is loaded on entry to PRST, so use the word index that PRST will see.
        word_next      = (state == VOTE) ? word_idx + 3'd1 : word_idx;
        challenge_next = (state == IDLE) ? bus.seed : (seed_q ^ {4{1'b0, word_next}});

        word_bits = '0;
        for (int i = 0; i < 16; i++) word_bits[i] = (votes[i] > HALF);

`ifdef PUF_UNSTABLE_FLAG_EN
        flaky     = '0;
        flaky_cnt = '0;
        for (int i = 0; i < 16; i++) begin
            flaky[i]  = (votes[i] != 4'd0) && (votes[i] != ALL);
            flaky_cnt = flaky_cnt + 5'(flaky[i]);
        end
`endif
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state             <= IDLE;
            settle_cnt        <= '0;
            sample_cnt        <= '0;
            word_idx          <= '0;
            seed_q            <= '0;
            for (int i = 0; i < 16; i++) votes[i] <= '0;
            bus.puf_challenge <= '0;
            bus.puf_rst       <= 1'b1;
            bus.busy          <= 1'b0;
            bus.key_valid     <= 1'b0;
            bus.key           <= '0;
`ifdef PUF_UNSTABLE_FLAG_EN
            bus.unstable_mask <= '0;
            bus.unstable_cnt  <= '0;
`endif
        end else begin
            state       <= state_next;
            bus.puf_rst <= (state_next == IDLE) || (state_next == PRST);
            bus.busy    <= (state_next != IDLE);
            if (state_next == PRST) bus.puf_challenge <= challenge_next;

            case (state)
                IDLE: if (bus.start) begin
                    seed_q        <= bus.seed;
                    word_idx      <= '0;
                    bus.key_valid <= 1'b0;
`ifdef PUF_UNSTABLE_FLAG_EN
                    bus.unstable_mask <= '0;
                    bus.unstable_cnt  <= '0;
`endif
                end
                SETTLE: settle_cnt <= (settle_cnt == SETTLE_LAST) ? '0 : settle_cnt + 1'b1;
                CAP: begin
                    for (int i = 0; i < 16; i++) votes[i] <= votes[i] + {3'b000, bus.puf_resp[i]};
                    sample_cnt <= sample_cnt + 4'd1;
                end
                VOTE: begin
                    bus.key[{word_idx, 4'b0000} +: 16] <= word_bits;
`ifdef PUF_UNSTABLE_FLAG_EN
                    bus.unstable_mask[{word_idx, 4'b0000} +: 16] <= flaky;
                    bus.unstable_cnt <= bus.unstable_cnt + {3'b000, flaky_cnt};
`endif
                    for (int i = 0; i < 16; i++) votes[i] <= '0;
                    sample_cnt <= '0;
                    if (word_idx == 3'd7) bus.key_valid <= 1'b1;
                    else                  word_idx      <= word_idx + 3'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_puf_key_accumulator.sv
// tb/tb_puf_key_accumulator.sv - directed bench for puf_key_accumulator with a modelled PUF
module tb_puf_key_accumulator;
    localparam int SC = 4;
    localparam int NS = 3;
    localparam logic [127:0] KEY_A = 128'h331D_220C_113F_002E_7759_6648_557B_446A;
    localparam logic [127:0] KEY_B = 128'hB791_A680_95B3_84A2_F3D5_E2C4_D1F7_C0E6;

    logic clk = 1'b0;
    logic Reset;
    always #5 clk = ~clk;

    puf_key_accumulator_if bus();
    puf_key_accumulator #(.SETTLE_CYCLES(SC), .NUM_SAMPLES(NS)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;
    logic noisy = 1'b0;
    int rst_cycles   = 0;
    int chal_changes = 0;
    int chal_bad     = 0;
    logic [0:15] prev_chal = '0;
    int lat;
    bit found;

    // PUF model: response tracks the challenge; noisy mode flips bit 3 on the third sample of each word.
    assign bus.puf_resp = bus.puf_challenge ^ 16'hA5A5 ^
        ((noisy && rst_cycles > 0 && ((rst_cycles - 1) % 3) == 2) ? 16'h1000 : 16'h0000);

    always @(negedge clk) begin
        prev_chal <= bus.puf_challenge;
        if (!bus.busy) begin
            rst_cycles   <= 0;
            chal_changes <= 0;
            chal_bad     <= 0;
        end else begin
            if (bus.puf_rst) rst_cycles <= rst_cycles + 1;
            if (bus.puf_challenge != prev_chal) begin
                if (bus.puf_rst) chal_changes <= chal_changes + 1;
                else             chal_bad     <= chal_bad + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [0:15] s, input bit pulses, output int latency);
        bit done;
        @(negedge clk);
        bus.seed  = s;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.seed  = 16'hFFFF;
        check("busy_rise", 128'(bus.busy), 128'(1));
        check("kv_cleared", 128'(bus.key_valid), 128'(0));
        latency = 0;
        done    = 1'b0;
        while (!done && latency < 400) begin
            @(posedge clk);
            #1;
            latency++;
            if (bus.key_valid) done = 1'b1;
            else bus.start = pulses && (latency % 20 == 5);
        end
        bus.start = 1'b0;
        check("busy_fall_with_kv", 128'(bus.busy), 128'(0));
    endtask

    initial begin
        Reset     = 1'b0;
        bus.start = 1'b0;
        bus.seed  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 128'(bus.busy), 128'(0));
        check("rst_kv", 128'(bus.key_valid), 128'(0));
        check("rst_key", bus.key, 128'(0));
        check("rst_chal", 128'(bus.puf_challenge), 128'(0));
        check("rst_puf_rst", 128'(bus.puf_rst), 128'(1));
        @(negedge clk);
        Reset = 1'b1;

        run(16'b1001011010111000, 1'b0, lat);
        check("stable_latency", 128'(lat), 128'(152));
        check("stable_key", bus.key, KEY_A);
        check("stable_rst_pulses", 128'(rst_cycles), 128'(24));
        check("stable_chal_changes", 128'(chal_changes), 128'(8));
        check("stable_chal_outside_prst", 128'(chal_bad), 128'(0));
`ifdef PUF_UNSTABLE_FLAG_EN
        check("stable_unstable_cnt", 128'(bus.unstable_cnt), 128'(0));
        check("stable_unstable_mask", bus.unstable_mask, 128'(0));
`endif

        noisy = 1'b1;
        run(16'h96B8, 1'b1, lat);
        check("noisy_pulsed_latency", 128'(lat), 128'(152));
        check("noisy_key", bus.key, KEY_A);
        check("noisy_rst_pulses", 128'(rst_cycles), 128'(24));
`ifdef PUF_UNSTABLE_FLAG_EN
        check("noisy_unstable_cnt", 128'(bus.unstable_cnt), 128'(8));
        check("noisy_unstable_mask", bus.unstable_mask, {8{16'h1000}});
`endif
        noisy = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        check("hold_kv", 128'(bus.key_valid), 128'(1));
        check("hold_key", bus.key, KEY_A);

        run(16'h1234, 1'b0, lat);
        check("b2b_latency", 128'(lat), 128'(152));
        check("b2b_key", bus.key, KEY_B);

        @(negedge clk);
        bus.seed  = 16'h1234;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(posedge clk);
            #1;
            if (bus.puf_challenge == 16'h5670 && !bus.puf_rst) found = 1'b1;
        end
        check("reach_word4_settle", 128'(found), 128'(1));
        #2;
        Reset = 1'b0;
        #1;
        check("abort_busy", 128'(bus.busy), 128'(0));
        check("abort_key", bus.key, 128'(0));
        check("abort_kv", 128'(bus.key_valid), 128'(0));
        check("abort_puf_rst", 128'(bus.puf_rst), 128'(1));
        check("abort_chal", 128'(bus.puf_challenge), 128'(0));
        @(posedge clk);
        #3;
        Reset = 1'b1;

        run(16'h96B8, 1'b0, lat);
        check("post_abort_latency", 128'(lat), 128'(152));
        check("post_abort_key", bus.key, KEY_A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/puf_key_accumulator.md
# puf_key_accumulator

Sequencer and majority-vote filter placed directly downstream of the ring-oscillator PUF. It drives the PUF challenge and PUF reset, re-evaluates each challenge several times, and majority-votes every response bit to suppress PUF noise. It concatenates eight stabilised 16-bit responses into the 128-bit key consumed by the AES key schedule.

## Interface
- `SETTLE_CYCLES`, default 64: cycles the PUF runs after its reset is released before its response is captured; must be ≥1.
- `NUM_SAMPLES`, default 5: evaluations per challenge; must be odd, 1..15.
- `clk` input 1: system clock; all logic is rising-edge.
- `Reset` input 1: asynchronous, active-low (0 = reset). One clock; reset is asynchronous and active-low.
- `start` input 1: key-generation request, sampled only in IDLE.
- `seed` input [0:15]: base challenge, captured when `start` is accepted.
- `puf_resp` input [0:15]: PUF `Out`.
- `puf_challenge` output [0:15]: PUF challenge.
- `puf_rst` output 1: active-high reset to the PUF.
- `busy` output 1: high while a generation is in progress.
- `key_valid` output 1: `key` is complete and stable.
- `key` output [0:127]: generated key; word 0 is in `key[0:15]`, word 7 is in `key[112:127]`.

## Operation
- Reset values:
  - `busy` = 0, `key_valid` = 0, `key` = 0, `puf_challenge` = 0, `puf_rst` = 1.
  - State is IDLE; all counters are 0.
- States:
  - **IDLE**: `puf_rst` = 1. If `start` = 1:
    - capture `seed`;
    - word index k = 0;
    - clear `key_valid`;
    - go to PRST.
  - **PRST** (1 cycle): `puf_rst` = 1, `puf_challenge` = seed ^ (16'h1111 × k), i.e. k replicated in every nibble. Then go to SETTLE.
  - **SETTLE** (`SETTLE_CYCLES` cycles): `puf_rst` = 0, challenge held. Then go to CAP.
  - **CAP** (1 cycle): `puf_rst` = 0; add `puf_resp[i]` into 4-bit vote counter i (i = 0..15); increment the sample counter.
    - If sample counter < `NUM_SAMPLES`: go to PRST.
    - Otherwise: go to VOTE.
  - **VOTE** (1 cycle):
    - bit i of word k = 1 iff counter i > `NUM_SAMPLES`/2 (integer division);
    - write the word into `key[16k:16k+15]`;
    - clear the vote counters and sample counter.
    - If k = 7: set `key_valid`, go to IDLE. Otherwise: k++, go to PRST.
- `busy` = 1 in every state except IDLE.
- `start` while busy is ignored, not queued.
- `key` and `key_valid` hold after completion until the next accepted `start`. That start clears `key_valid` the following cycle; `key` is overwritten word by word.
- `Reset` asserted mid-run aborts immediately; all registers return to reset values. No partial key is retained.
- Vote counters never exceed 15 (`NUM_SAMPLES` ≤ 15), so no wrap occurs.

## Timing
- Per word: `NUM_SAMPLES` × (`SETTLE_CYCLES` + 2) + 1 cycles.
- Latency L = 8 × (`NUM_SAMPLES` × (`SETTLE_CYCLES` + 2) + 1) cycles. `key_valid` is first high exactly L cycles after the edge that accepts `start`.
  - Defaults: L = 2648.
  - `SETTLE_CYCLES` = 4, `NUM_SAMPLES` = 3: L = 152.
- `busy` rises the cycle after `start` is accepted. `busy` falls in the same cycle `key_valid` rises.
- `puf_resp` is sampled only on the CAP edge; its value at any other time is don't-care.
- All outputs are registered.

## Configuration
- `PUF_UNSTABLE_FLAG_EN` defined: adds two outputs.
  - `unstable_mask` [0:127]: bit set where a vote was not unanimous (counter ≠ 0 and ≠ `NUM_SAMPLES`).
  - `unstable_cnt` [7:0]: population count of the mask, 0..128.
  - Both are reset to 0, cleared on accepted `start`, and valid with `key_valid`.
- Undefined: these ports and their logic are absent. `key` behaviour is identical in both builds.

## Test plan
- **Stable PUF**: model `puf_resp` = challenge ^ 16'hA5A5; `SETTLE_CYCLES` = 4, `NUM_SAMPLES` = 3; `start` with `seed` = 16'b1001011010111000.
  - `key_valid` rises exactly 152 cycles later.
  - Word k = (16'h96B8 ^ 16'h1111×k) ^ 16'hA5A5.
  - `unstable_cnt` = 0.
- **Noisy PUF**: same model, but bit 3 is inverted on sample 2 of every word.
  - `key` is unchanged from the stable case.
  - With the macro defined: `unstable_cnt` = 8, and `unstable_mask` has bit 16k+3 set for k = 0..7.
- **Reset during SETTLE of word 4**: drive `Reset` = 0 for 1 cycle.
  - `busy` = 0, `key` = 0, `key_valid` = 0, `puf_rst` = 1 immediately (asynchronously).
  - A new `start` then completes normally in 152 cycles.
- **`start` pulses while busy**: no effect; completion cycle is unchanged.
- **Back-to-back runs**: `start` again after `key_valid` with a new `seed`.
  - `key_valid` drops the next cycle.
  - The new key appears after 152 cycles.
- **PUF reset and challenge sequencing**: for each word, `puf_rst` pulses exactly `NUM_SAMPLES` times, one cycle each. `puf_challenge` changes only in PRST of sample 0.
